// File: rtl/game_control.sv
// Memory-game sequencer: shows a growing LFSR tile sequence, then checks the player's answers.
// Moore outputs from the state register; waits indefinitely on the player stage (no input timeout).
module game_control #(
  parameter int TICKS = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  KEY,
  input  logic        player_input,
  input  logic        check,
  output logic [17:0] seq,
  output logic [3:0]  seq_counter,
  output logic        playerEN,
  output logic        checkEN,
  output logic        show_valid,
  output logic [1:0]  show_tile,
  output logic [3:0]  round,
  output logic        win,
  output logic        lose
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GEN,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_WAIT_REL,
    S_INPUT,
    S_CHK_REQ,
    S_CHK_WAIT,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [17:0] LFSR_SEED = 18'h2A5A5;
  localparam logic [24:0] TICK_LAST = 25'(TICKS - 1);
  localparam logic [3:0]  MAX_ROUND = 4'd9;

  state_t      state;
  state_t      state_nxt;
  logic [17:0] lfsr;
  logic [17:0] seq_nxt;
  logic [24:0] tick_cnt;
  logic [3:0]  seq_counter_nxt;
  logic [3:0]  round_nxt;
  logic        tick_done;
  logic        more_tiles;
  logic [1:0]  tile_raw;

  assign tick_done  = (tick_cnt == TICK_LAST);
  assign more_tiles = (seq_counter < (round - 4'd1));

  // Free-running so the seed captured at GEN depends on how long the player idled.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[16:0], lfsr[17] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      tick_cnt    <= '0;
      seq         <= '0;
      seq_counter <= '0;
      round       <= '0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= (state_nxt != state) ? '0 : tick_cnt + 25'd1;
      seq         <= seq_nxt;
      seq_counter <= seq_counter_nxt;
      round       <= round_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    seq_nxt         = seq;
    seq_counter_nxt = seq_counter;
    round_nxt       = round;
    case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) state_nxt = S_GEN;
      end
      S_GEN: begin
        seq_nxt         = lfsr;
        round_nxt       = 4'd1;
        seq_counter_nxt = '0;
        state_nxt       = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (tick_done) state_nxt = S_SHOW_OFF;
      end
      S_SHOW_OFF: begin
        if (tick_done) begin
          if (more_tiles) begin
            seq_counter_nxt = seq_counter + 4'd1;
            state_nxt       = S_SHOW_ON;
          end else begin
            seq_counter_nxt = '0;
            state_nxt       = S_WAIT_REL;
          end
        end
      end
      S_WAIT_REL: begin
        // All keys released and the player stage idle, so one press yields one answer.
        if ((KEY == 4'hF) && !player_input) state_nxt = S_INPUT;
      end
      S_INPUT: begin
        if (player_input) state_nxt = S_CHK_REQ;
      end
      S_CHK_REQ: begin
        state_nxt = S_CHK_WAIT;
      end
      S_CHK_WAIT: begin
        if (!check) begin
          state_nxt = S_LOSE;
        end else if (more_tiles) begin
          seq_counter_nxt = seq_counter + 4'd1;
          state_nxt       = S_WAIT_REL;
        end else if (round < MAX_ROUND) begin
          round_nxt       = round + 4'd1;
          seq_counter_nxt = '0;
          state_nxt       = S_SHOW_ON;
        end else begin
          state_nxt = S_WIN;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Tile i sits at {seq[2i], seq[2i+1]}, so the lower bit index is the MSB.
  assign tile_raw = 2'(seq >> {seq_counter, 1'b0});

  assign show_valid = (state == S_SHOW_ON);
  assign show_tile  = show_valid ? {tile_raw[0], tile_raw[1]} : 2'b00;
  assign playerEN   = (state == S_INPUT);
  assign checkEN    = (state == S_CHK_REQ);
  assign win        = (state == S_WIN);
  assign lose       = (state == S_LOSE);

endmodule

// File: doc/game_control.md
GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 Parameter: TICKS, 25000000, cycles per tile-show and per gap (bench uses 4).
REQ-002 clk  in  1  sole clock, all state on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 start  in  1  level; begins new game when sampled high in IDLE, WIN or LOSE.
REQ-005 KEY  in  4  raw active-low player keys, release detection only.
REQ-006 player_input  in  1  from player stage; high once a key was latched during playerEN.
REQ-007 check  in  1  from player stage; 1 = latched tile matches seq at seq_counter.
REQ-008 seq  out  18  nine 2-bit tiles; tile i = {seq[2i] (MSB), seq[2i+1] (LSB)}.
REQ-009 seq_counter  out  4  tile index currently shown or expected, 0..8.
REQ-010 playerEN  out  1  player stage may latch keys.
REQ-011 checkEN  out  1  player stage shall compare on this cycle.
REQ-012 show_valid  out  1  a tile is being displayed.
REQ-013 show_tile  out  2  tile being displayed, valid with show_valid.
REQ-014 round  out  4  current sequence length L, 1..9; 0 in IDLE.
REQ-015 win  out  1  / lose  out  1  terminal status flags.

Function
REQ-016 States: IDLE, GEN, SHOW_ON, SHOW_OFF, WAIT_REL, INPUT, CHK_REQ, CHK_WAIT, WIN, LOSE; outputs Moore-decoded from state register.
REQ-017 18-bit Fibonacci LFSR, taps x^18+x^11+1, shifts every cycle in all states.
REQ-018 IDLE/WIN/LOSE with start=1 -> GEN; otherwise hold.
REQ-019 GEN (one cycle): seq <= LFSR value, round <= 1, seq_counter <= 0, win/lose <= 0 -> SHOW_ON.
REQ-020 SHOW_ON: show_valid=1, show_tile = tile seq_counter, exactly TICKS cycles -> SHOW_OFF.
REQ-021 SHOW_OFF: show_valid=0, exactly TICKS cycles; if seq_counter < round-1 increment and -> SHOW_ON, else seq_counter <= 0 -> WAIT_REL.
REQ-022 Tick counter: 25 bits, cleared on every state entry, saturates never (compare to TICKS-1).
REQ-023 WAIT_REL: playerEN=0; -> INPUT only when KEY == 4'hF and player_input == 0.
REQ-024 INPUT: playerEN=1; player_input=1 -> CHK_REQ; no timeout.
REQ-025 CHK_REQ: playerEN=0, checkEN=1 for exactly one cycle -> CHK_WAIT.
REQ-026 CHK_WAIT: checkEN=0, samples check this cycle; check=0 -> LOSE.
REQ-027 check=1, seq_counter < round-1: seq_counter++ -> WAIT_REL.
REQ-028 check=1, seq_counter = round-1, round < 9: round++, seq_counter <= 0 -> SHOW_ON (full replay, same seq).
REQ-029 check=1, seq_counter = round-1, round = 9 -> WIN.
REQ-030 WIN: win=1; LOSE: lose=1; both hold round, seq, seq_counter; playerEN/checkEN/show_valid = 0.
REQ-031 player_input ignored outside INPUT; start ignored outside IDLE/WIN/LOSE.
REQ-032 playerEN and checkEN never high in the same cycle; playerEN low >= 2 cycles between inputs.

Reset
REQ-033 reset=1 at posedge -> IDLE; seq=0, seq_counter=0, round=0, all 1-bit outputs 0, tick counter 0, LFSR = 18'h2A5A5.
REQ-034 reset mid-game (any state) takes priority over all transitions; no partial output pulse after it.

Verification (TICKS=4, bench models player stage)
REQ-035 Reset 3 cycles -> all outputs 0, round=0; next cycle LFSR has shifted from 18'h2A5A5.
REQ-036 start=1 from IDLE -> GEN 1 cycle, seq = bench LFSR model, round=1; show_valid high exactly 4 cycles with show_tile={seq[0],seq[1]}, low 4, then playerEN=1, seq_counter=0.
REQ-037 In INPUT, player_input=1 -> next cycle playerEN=0, checkEN=1 one cycle; check=1 in CHK_WAIT -> round=2, two tile-shows (tiles 0,1) replayed.
REQ-038 check=0 in CHK_WAIT -> lose=1 held 20 cycles, playerEN=0; start=1 -> new GEN, lose=0.
REQ-039 After correct check, KEY=4'b1110 held 10 cycles -> playerEN stays 0; KEY=4'hF -> playerEN=1 next cycle.
REQ-040 Nine rounds all correct -> win=1, round=9, seq unchanged since GEN; reset asserted mid-SHOW_ON of round 5 -> IDLE, round=0 next cycle.
